// File: rtl/rmii_rx_fcs_check_if.sv
// RMII receive bundle: dibit pins in, payload byte stream and end-of-frame status out.
// The checker takes the master side; the RX buffer (or a bench) takes the slave side.
interface rmii_rx_fcs_check_if #(
  parameter int unsigned LEN_W = 11
);
  logic             crs_dv;
  logic [1:0]       rxd;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_done;
  logic             rx_fcs_ok;
  logic             rx_err_align;
  logic             rx_err_short;
  logic             rx_err_long;
  logic [LEN_W-1:0] rx_len;

  modport master (
    input  crs_dv, rxd,
    output rx_data, rx_valid, rx_done, rx_fcs_ok, rx_err_align, rx_err_short, rx_err_long,
           rx_len
  );

  modport slave (
    output crs_dv, rxd,
    input  rx_data, rx_valid, rx_done, rx_fcs_ok, rx_err_align, rx_err_short, rx_err_long,
           rx_len
  );
endinterface

// File: rtl/rmii_rx_fcs_check.sv
// RMII 100 Mb/s receive checker: strips preamble/SFD, assembles bytes, checks the CRC-32
// residue and withholds the trailing 4 FCS bytes from the payload stream.
module rmii_rx_fcs_check #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518,
  parameter int unsigned LEN_W   = 11
) (
  input  logic                clk,
  input  logic                reset,
  rmii_rx_fcs_check_if.master bus
);

  localparam logic [31:0]      CrcPoly    = 32'hEDB88320;
  localparam logic [31:0]      CrcResidue = 32'hDEBB20E3;
  localparam logic [LEN_W-1:0] MaxCnt     = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] MinCnt     = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] FcsCnt     = LEN_W'(4);

  typedef enum logic [1:0] {StDrop, StIdle, StPreamble, StData} state_e;

  // Two reflected CRC steps, rxd[0] first.
  function automatic logic [31:0] crc_step2(input logic [31:0] crc, input logic [1:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 2; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ CrcPoly;
      else             c = c >> 1;
    end
    return c;
  endfunction

  state_e           state_q, state_d;
  logic             silent_q, silent_d;
  logic             long_q, long_d;
  logic [31:0]      crc_q, crc_d;
  logic [5:0]       shift_q, shift_d;
  logic [1:0]       phase_q, phase_d;
  logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [3:0][7:0]  fifo_q, fifo_d;
  logic [2:0]       fifo_cnt_q, fifo_cnt_d;

  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_done_q, rx_done_d;
  logic             rx_fcs_ok_q, rx_fcs_ok_d;
  logic             rx_err_align_q, rx_err_align_d;
  logic             rx_err_short_q, rx_err_short_d;
  logic             rx_err_long_q, rx_err_long_d;
  logic [LEN_W-1:0] rx_len_q, rx_len_d;

  logic [7:0]       new_byte;

  assign new_byte = {bus.rxd, shift_q};

  always_comb begin
    state_d        = state_q;
    silent_d       = silent_q;
    long_d         = long_q;
    crc_d          = crc_q;
    shift_d        = shift_q;
    phase_d        = phase_q;
    byte_cnt_d     = byte_cnt_q;
    fifo_d         = fifo_q;
    fifo_cnt_d     = fifo_cnt_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rx_done_d      = 1'b0;
    rx_fcs_ok_d    = 1'b0;
    rx_err_align_d = 1'b0;
    rx_err_short_d = 1'b0;
    rx_err_long_d  = 1'b0;
    rx_len_d       = '0;

    case (state_q)
      StDrop: begin
        if (!bus.crs_dv) begin
          state_d  = StIdle;
          silent_d = 1'b0;
          long_d   = 1'b0;
          if (!silent_q) begin
            rx_done_d      = 1'b1;
            rx_len_d       = byte_cnt_q;
            rx_err_long_d  = long_q;
            rx_err_short_d = (byte_cnt_q < MinCnt);
          end
        end
      end
      StIdle: begin
        if (bus.crs_dv) begin
          if (bus.rxd == 2'b01) begin
            state_d = StPreamble;
          end else if (bus.rxd != 2'b00) begin
            state_d  = StDrop;
            silent_d = 1'b1;
          end
        end
      end
      StPreamble: begin
        if (!bus.crs_dv) begin
          state_d = StIdle;
        end else begin
          case (bus.rxd)
            2'b01: state_d = StPreamble;
            2'b11: begin
              state_d    = StData;
              crc_d      = '1;
              shift_d    = '0;
              phase_d    = '0;
              byte_cnt_d = '0;
              fifo_cnt_d = '0;
              long_d     = 1'b0;
            end
            default: begin
              state_d  = StDrop;
              silent_d = 1'b1;
            end
          endcase
        end
      end
      StData: begin
        if (bus.crs_dv) begin
          shift_d = {bus.rxd, shift_q[5:2]};
          crc_d   = crc_step2(crc_q, bus.rxd);
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd3) begin
            if (byte_cnt_q == MaxCnt) begin
              // Oversize: report saturated length once carrier drops.
              byte_cnt_d = MaxCnt + LEN_W'(1);
              long_d     = 1'b1;
              state_d    = StDrop;
              silent_d   = 1'b0;
            end else begin
              byte_cnt_d = byte_cnt_q + LEN_W'(1);
              fifo_d     = {new_byte, fifo_q[3:1]};
              if (fifo_cnt_q == 3'd4) begin
                rx_valid_d = 1'b1;
                rx_data_d  = fifo_q[0];
              end else begin
                fifo_cnt_d = fifo_cnt_q + 3'd1;
              end
            end
          end
        end else begin
          state_d        = StIdle;
          rx_done_d      = 1'b1;
          rx_len_d       = byte_cnt_q;
          rx_err_align_d = (phase_q != 2'd0);
          rx_err_short_d = (byte_cnt_q < MinCnt);
          rx_fcs_ok_d    = (phase_q == 2'd0) && (byte_cnt_q >= FcsCnt) && (crc_q == CrcResidue);
        end
      end
      default: begin
        state_d  = StDrop;
        silent_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StDrop;
      silent_q       <= 1'b1;
      long_q         <= 1'b0;
      crc_q          <= '1;
      shift_q        <= '0;
      phase_q        <= '0;
      byte_cnt_q     <= '0;
      fifo_q         <= '0;
      fifo_cnt_q     <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rx_done_q      <= 1'b0;
      rx_fcs_ok_q    <= 1'b0;
      rx_err_align_q <= 1'b0;
      rx_err_short_q <= 1'b0;
      rx_err_long_q  <= 1'b0;
      rx_len_q       <= '0;
    end else begin
      state_q        <= state_d;
      silent_q       <= silent_d;
      long_q         <= long_d;
      crc_q          <= crc_d;
      shift_q        <= shift_d;
      phase_q        <= phase_d;
      byte_cnt_q     <= byte_cnt_d;
      fifo_q         <= fifo_d;
      fifo_cnt_q     <= fifo_cnt_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rx_done_q      <= rx_done_d;
      rx_fcs_ok_q    <= rx_fcs_ok_d;
      rx_err_align_q <= rx_err_align_d;
      rx_err_short_q <= rx_err_short_d;
      rx_err_long_q  <= rx_err_long_d;
      rx_len_q       <= rx_len_d;
    end
  end

  assign bus.rx_data      = rx_data_q;
  assign bus.rx_valid     = rx_valid_q;
  assign bus.rx_done      = rx_done_q;
  assign bus.rx_fcs_ok    = rx_fcs_ok_q;
  assign bus.rx_err_align = rx_err_align_q;
  assign bus.rx_err_short = rx_err_short_q;
  assign bus.rx_err_long  = rx_err_long_q;
  assign bus.rx_len       = rx_len_q;

endmodule
